// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter slice: default geometry,
// requester indices and arbitration modes.
package dmem_pkg;

    localparam int DMEM_S  = 32;
    localparam int DMEM_L  = 256;
    localparam int DMEM_AW = $clog2(DMEM_L);

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational picker: fixed priority to the CPU, or round-robin
// where the requester that did not win last time takes a tie.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio,
    output logic [1:0] gnt
);

    // The CPU takes a tie when priority is fixed or when the debug port won last.
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && (!req[REQ_DBG] || prio || (last == REQ_DBG))) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_DBG]) begin
            gnt[REQ_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data-memory port between the CPU load/store path and
// the loader/debug port; read data returns one cycle after the grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int S    = DMEM_S,
    parameter int L    = DMEM_L,
    parameter int AW   = $clog2(L),
    parameter int PRIO = int'(ARB_RR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [S-1:0]  wdata0,
    input  logic [S-1:0]  wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [S-1:0]  rdata0,
    output logic [S-1:0]  rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] mem_a,
    output logic [S-1:0]  mem_din,
    output logic          mem_mread,
    output logic          mem_mwrite,
    input  logic [S-1:0]  mem_dout
);

    logic [1:0] req_live;
    logic [1:0] gnt;
    logic       last;
    logic       prio;

    // Masking the requests with reset keeps grants and memory strobes low
    // for the whole reset cycle, not just after the edge.
    assign req_live = {req1, req0} & {2{rst_n}};
    assign prio     = (PRIO == int'(ARB_FIXED));

    rr_arb2 u_pick (
        .req  (req_live),
        .last (last),
        .prio (prio),
        .gnt  (gnt)
    );

    assign gnt0 = gnt[REQ_CPU];
    assign gnt1 = gnt[REQ_DBG];

    always_comb begin
        mem_a      = '0;
        mem_din    = '0;
        mem_mread  = 1'b0;
        mem_mwrite = 1'b0;
        if (gnt[REQ_CPU]) begin
            mem_a      = addr0;
            mem_din    = wdata0;
            mem_mwrite = we0;
            mem_mread  = ~we0;
        end else if (gnt[REQ_DBG]) begin
            mem_a      = addr1;
            mem_din    = wdata1;
            mem_mwrite = we1;
            mem_mread  = ~we1;
        end
    end

    // last starts at the debug port so the CPU wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last    <= REQ_DBG;
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt[REQ_CPU] & ~we0;
            rvalid1 <= gnt[REQ_DBG] & ~we1;
            if (gnt[REQ_CPU] && !we0) begin
                rdata0 <= mem_dout;
            end
            if (gnt[REQ_DBG] && !we1) begin
                rdata1 <= mem_dout;
            end
            if (|gnt) begin
                last <= gnt[REQ_DBG];
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side from one
// vector table, each with its own memory; read data is tracked in a scoreboard.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int S  = DMEM_S;
    localparam int L  = DMEM_L;
    localparam int AW = DMEM_AW;

    typedef struct {
        string         name;
        logic          rst_n;
        logic          req0;
        logic          we0;
        logic [AW-1:0] addr0;
        logic [S-1:0]  wdata0;
        logic          req1;
        logic          we1;
        logic [AW-1:0] addr1;
        logic [S-1:0]  wdata1;
        logic [1:0]    g_rr;
        logic [1:0]    g_fx;
    } vec_t;

    typedef struct {
        int           inst;
        int           who;
        logic [S-1:0] data;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n, req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [S-1:0]  wdata0, wdata1;

    logic          gnt0 [2];
    logic          gnt1 [2];
    logic          rvalid0 [2];
    logic          rvalid1 [2];
    logic          mem_mread [2];
    logic          mem_mwrite [2];
    logic [S-1:0]  rdata0 [2];
    logic [S-1:0]  rdata1 [2];
    logic [S-1:0]  mem_din [2];
    logic [S-1:0]  mem_dout [2];
    logic [AW-1:0] mem_a [2];

    logic [S-1:0]  shadow [2][L];
    logic [S-1:0]  exp_rdata0 [2];
    logic [S-1:0]  exp_rdata1 [2];
    sb_t           sbq [$];
    vec_t          vecs [$];
    string         cur_name;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    function automatic logic [S-1:0] init_word(input int k);
        return (k == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k));
    endfunction

    // Instance 0 is round-robin, instance 1 fixed priority.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [S-1:0] mem [L];

        initial for (int k = 0; k < L; k++) mem[k] = init_word(k);

        always @(posedge clk) if (mem_mwrite[gi]) mem[mem_a[gi]] = mem_din[gi];

        assign mem_dout[gi] = mem[mem_a[gi]];

        dmem_arbiter #(.S(S), .L(L), .AW(AW), .PRIO(gi)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0       (req0),
            .req1       (req1),
            .we0        (we0),
            .we1        (we1),
            .addr0      (addr0),
            .addr1      (addr1),
            .wdata0     (wdata0),
            .wdata1     (wdata1),
            .gnt0       (gnt0[gi]),
            .gnt1       (gnt1[gi]),
            .rdata0     (rdata0[gi]),
            .rdata1     (rdata1[gi]),
            .rvalid0    (rvalid0[gi]),
            .rvalid1    (rvalid1[gi]),
            .mem_a      (mem_a[gi]),
            .mem_din    (mem_din[gi]),
            .mem_mread  (mem_mread[gi]),
            .mem_mwrite (mem_mwrite[gi]),
            .mem_dout   (mem_dout[gi])
        );
    end

    function automatic vec_t mk(input string n, input logic rst,
                                input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [S-1:0] d0,
                                input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [S-1:0] d1,
                                input logic [1:0] grr, input logic [1:0] gfx);
        vec_t v;
        v.name = n;   v.rst_n = rst;
        v.req0 = r0;  v.we0 = w0;  v.addr0 = a0;  v.wdata0 = d0;
        v.req1 = r1;  v.we1 = w1;  v.addr1 = a1;  v.wdata1 = d1;
        v.g_rr = grr; v.g_fx = gfx;
        return v;
    endfunction

    task automatic check(input string what, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d vec=%s actual=%h expected=%h", what, inst, cur_name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        for (int i = 0; i < 2; i++) begin
            logic [1:0]    g;
            logic          ev0, ev1, ew, er;
            logic [AW-1:0] ea;
            logic [S-1:0]  ed;
            g   = (i == 0) ? v.g_rr : v.g_fx;
            ev0 = 1'b0;
            ev1 = 1'b0;
            for (int k = 0; k < sbq.size(); k++) begin
                if (sbq[k].inst == i) begin
                    if (sbq[k].who == 0) begin
                        ev0 = 1'b1;
                        exp_rdata0[i] = sbq[k].data;
                    end else begin
                        ev1 = 1'b1;
                        exp_rdata1[i] = sbq[k].data;
                    end
                    sbq.delete(k);
                    break;
                end
            end
            ea = '0; ed = '0; ew = 1'b0; er = 1'b0;
            if (g == 2'b01) begin
                ea = v.addr0; ed = v.wdata0; ew = v.we0; er = !v.we0;
            end else if (g == 2'b10) begin
                ea = v.addr1; ed = v.wdata1; ew = v.we1; er = !v.we1;
            end
            check("gnt0",       i, 32'(gnt0[i]),       32'(g[0]));
            check("gnt1",       i, 32'(gnt1[i]),       32'(g[1]));
            check("mem_a",      i, 32'(mem_a[i]),      32'(ea));
            check("mem_din",    i, 32'(mem_din[i]),    32'(ed));
            check("mem_mwrite", i, 32'(mem_mwrite[i]), 32'(ew));
            check("mem_mread",  i, 32'(mem_mread[i]),  32'(er));
            check("rvalid0",    i, 32'(rvalid0[i]),    32'(ev0));
            check("rvalid1",    i, 32'(rvalid1[i]),    32'(ev1));
            check("rdata0",     i, 32'(rdata0[i]),     32'(exp_rdata0[i]));
            check("rdata1",     i, 32'(rdata1[i]),     32'(exp_rdata1[i]));
        end
    endtask

    // Expected effect of the coming posedge on the reference memory and scoreboard.
    task automatic modelEdge(input vec_t v);
        for (int i = 0; i < 2; i++) begin
            logic [1:0] g;
            g = (i == 0) ? v.g_rr : v.g_fx;
            if (!v.rst_n) begin
                for (int k = sbq.size() - 1; k >= 0; k--) if (sbq[k].inst == i) sbq.delete(k);
                exp_rdata0[i] = '0;
                exp_rdata1[i] = '0;
            end else if (g == 2'b01) begin
                if (v.we0) shadow[i][v.addr0] = v.wdata0;
                else sbq.push_back('{inst: i, who: 0, data: shadow[i][v.addr0]});
            end else if (g == 2'b10) begin
                if (v.we1) shadow[i][v.addr1] = v.wdata1;
                else sbq.push_back('{inst: i, who: 1, data: shadow[i][v.addr1]});
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cur_name = v.name;
        rst_n  = v.rst_n;
        req0   = v.req0;  we0 = v.we0;  addr0 = v.addr0;  wdata0 = v.wdata0;
        req1   = v.req1;  we1 = v.we1;  addr1 = v.addr1;  wdata1 = v.wdata1;
        @(negedge clk);
        checkOutput(v);
        modelEdge(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_rdata0[i] = '0;
            exp_rdata1[i] = '0;
            for (int k = 0; k < L; k++) shadow[i][k] = init_word(k);
        end
        cur_name = "pre";
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 3; r++)
            vecs.push_back(mk("rst", 1'b0, 1'b1, 1'b1, 8'h10, 32'h0, 1'b1, 1'b0, 8'h11, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk("rd1",    1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0, 2'b10, 2'b10));
        vecs.push_back(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk("ct1",    1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0, 8'h31, 32'h0, 2'b01, 2'b01));
        vecs.push_back(mk("ct2",    1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0, 8'h31, 32'h0, 2'b10, 2'b01));
        vecs.push_back(mk("ct3",    1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0, 8'h31, 32'h0, 2'b01, 2'b01));
        vecs.push_back(mk("ct4",    1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b0, 8'h31, 32'h0, 2'b10, 2'b01));
        vecs.push_back(mk("ctdrop", 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h31, 32'h0, 2'b10, 2'b10));
        vecs.push_back(mk("wr",     1'b1, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 2'b01));
        vecs.push_back(mk("rdaw",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 2'b10, 2'b10));
        vecs.push_back(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk("abtie",  1'b1, 1'b1, 1'b0, 8'h41, 32'h0, 1'b1, 1'b1, 8'h40, 32'hFFFFFFFF, 2'b01, 2'b01));
        vecs.push_back(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));
        vecs.push_back(mk("abchk",  1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h40, 32'h0, 2'b10, 2'b10));
        vecs.push_back(mk("wrtop",  1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'hFF, 32'hA5A5A5A5, 2'b10, 2'b10));
        vecs.push_back(mk("rdtop",  1'b1, 1'b1, 1'b0, 8'hFF, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 2'b01));
        vecs.push_back(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));

        for (int n = 0; n < vecs.size(); n++) applyStimulus(vecs[n]);

        // Reset lands while a read pulse is out; the following tie must go to the CPU.
        applyStimulus(mk("midrd",  1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b01, 2'b01));
        applyStimulus(mk("midrst", 1'b0, 1'b1, 1'b0, 8'h11, 32'h0, 1'b1, 1'b0, 8'h13, 32'h0, 2'b00, 2'b00));
        applyStimulus(mk("posttie",1'b1, 1'b1, 1'b0, 8'h12, 32'h0, 1'b1, 1'b0, 8'h13, 32'h0, 2'b01, 2'b01));
        applyStimulus(mk("tie2",   1'b1, 1'b1, 1'b0, 8'h12, 32'h0, 1'b1, 1'b0, 8'h13, 32'h0, 2'b10, 2'b01));
        applyStimulus(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));
        applyStimulus(mk("idle",   1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00));

        cur_name = "end";
        check("sb_drain", 0, 32'(sbq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
